// File: rtl/fifo_rd_drain.sv
// Read-side drain for sp_fifo: issues fifo_rd_en, captures fifo_dout after RD_LAT cycles, re-presents it as a valid/ready stream.
// Latency: fifo_rd_en seen in cycle C -> m_valid/m_data in cycle C+RD_LAT+1 (registered outputs, no bypass).
// Backpressure: reads are credit-limited so occupancy + in-flight never exceeds BUF_DEPTH; m_data held while m_valid & ~m_ready.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   en                  allow new FIFO reads (in-flight reads still land when low)
//   fifo_empty          registered empty flag from the FIFO
//   fifo_rd_en          read strobe to the FIFO
//   fifo_dout           FIFO read data, valid RD_LAT cycles after the strobe
//   m_valid/m_data      output stream (buffer head)
//   m_ready             downstream accept
//   busy                words buffered or reads in flight
//   xfer_cnt            accepted output transfers, wraps
module fifo_rd_drain #(
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [DW-1:0]    fifo_dout,
    output logic             m_valid,
    output logic [DW-1:0]    m_data,
    input  logic             m_ready,
    output logic             busy,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int OW = $clog2(BUF_DEPTH + 1);
    // wide enough for occ + inflight without overflow
    localparam int SW = $clog2(BUF_DEPTH + RD_LAT + 1) + 1;

    logic [OW-1:0]    occ_q, occ_d;
    logic [RD_LAT-1:0] infl_q;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [DW-1:0]    mem_q [BUF_DEPTH];
    logic             m_valid_q;
    logic [DW-1:0]    m_data_q;
    logic [CNT_W-1:0] xfer_cnt_q;
    logic             run_q;

    logic             pop;
    logic             push;
    logic             rd_en;
    logic [SW-1:0]    inflight;
    logic [SW-1:0]    credit_use;
    logic [DW-1:0]    head_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign pop  = m_valid_q & m_ready;
    assign push = infl_q[RD_LAT-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + SW'(infl_q[i]);
        end
    end

    // A word popped this cycle frees its slot in time for a read issued now,
    // so full-rate streaming holds with only RD_LAT+1 entries.
    assign credit_use = SW'(occ_q) + inflight - SW'(pop);

    // run_q keeps reads off until the first edge after reset release.
    assign rd_en = run_q & en & ~fifo_empty & (credit_use < SW'(BUF_DEPTH));

    always_comb begin
        occ_d    = occ_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({push, pop})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
        // The next head is the landing word when it is written into the
        // slot the read pointer will point at (empty buffer, or occ=1 with pop).
        if (push && (wr_ptr_q == rd_ptr_d)) head_d = fifo_dout;
        else                                head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= '0;
            infl_q     <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            xfer_cnt_q <= '0;
            run_q      <= 1'b0;
        end else begin
            run_q    <= 1'b1;
            occ_q    <= occ_d;
            infl_q   <= (infl_q << 1) | RD_LAT'(rd_en);
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            m_valid_q <= (occ_d != '0);
            if (occ_d != '0) m_data_q <= head_d;
            if (pop) xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
        end
    end

    // Storage needs no reset: occupancy alone says which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= fifo_dout;
    end

    // The credit rule makes a landing write into a full buffer impossible.
    always_ff @(posedge clk) begin
        if (rst_n && push && !pop) begin
            assert (occ_q != OW'(BUF_DEPTH))
                else $error("fifo_rd_drain: buffer overflow on landing read");
        end
    end

    assign fifo_rd_en = rd_en;
    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign busy       = (occ_q != '0) | (infl_q != '0);
    assign xfer_cnt   = xfer_cnt_q;

endmodule
